ritc_phase_scan_accumulator: RTL and testbench

Parametrised successor to the fixed 3x12 phase-scanner register bank. It takes already-clocked RITC sample bits (NUM_CH channels x NUM_BITS bits, plus per-channel clock and VCDL), resynchronises them into the user clock domain, and on request accumulates per-bit "ones" counts over a programmable number of samples. Software reads the results back through an indexed port to locate phase transitions. It sits between the RITC capture IOBs and the user-side register interface.

---
 rtl/ritc_phase_scan_pkg.sv | 28 ++
 rtl/ritc_phase_scan_accumulator_sync.sv | 27 ++
 rtl/ritc_phase_scan_accumulator.sv | 134 +++++++++++++
 tb/tb_ritc_phase_scan_accumulator.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ritc_phase_scan_pkg.sv
// Shared types and index helpers for the RITC phase-scan accumulator.
// Counter index map: data bits first, then per-channel clocks, then VCDL.
package ritc_phase_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DONE
  } scan_state_e;

  function automatic int calc_ncnt(input int num_ch, input int num_bits);
    return num_ch * num_bits + num_ch + 1;
  endfunction

  function automatic int clk_base(input int num_ch, input int num_bits);
    return num_ch * num_bits;
  endfunction

  function automatic int vcdl_index(input int num_ch, input int num_bits);
    return num_ch * num_bits + num_ch;
  endfunction

  function automatic logic addr_in_range(input int addr, input int ncnt);
    return (addr < ncnt);
  endfunction

endpackage

// File: rtl/ritc_phase_scan_accumulator_sync.sv
// Multi-stage resynchroniser for already-clocked RITC sample bits.
// Shift-register extraction is disabled so each stage stays a discrete flop.
module ritc_bit_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ritc_phase_scan_accumulator.sv
// Resynchronises RITC samples and accumulates per-bit ones counts over a
// programmable number of samples; results are read back by index.
module ritc_phase_scan_accumulator
  import ritc_phase_scan_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int NUM_BITS    = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                         user_clk_i,
  input  logic                         user_rst_n_i,
  input  logic [NUM_CH-1:0]            clk_in_i,
  input  logic [NUM_CH*NUM_BITS-1:0]   dat_in_i,
  input  logic                         vcdl_in_i,
  output logic [NUM_CH-1:0]            clk_q_o,
  output logic [NUM_CH*NUM_BITS-1:0]   dat_q_o,
  output logic                         vcdl_q_o,
  input  logic                         scan_start_i,
  input  logic                         scan_abort_i,
  input  logic [CNT_WIDTH-1:0]         scan_len_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         results_valid_o,
  input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
  output logic [CNT_WIDTH-1:0]         rd_data_o
);

  localparam int NDAT     = NUM_CH * NUM_BITS;
  localparam int NCNT     = calc_ncnt(NUM_CH, NUM_BITS);
  localparam int CLK_BASE = clk_base(NUM_CH, NUM_BITS);
  localparam int VCDL_IDX = vcdl_index(NUM_CH, NUM_BITS);
  localparam int SETTLE_W = $clog2(SYNC_STAGES) + 1;

  scan_state_e           state_q, next_state;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [CNT_WIDTH-1:0]  sample_cnt;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  cnt [NCNT];
  logic [CNT_WIDTH-1:0]  rd_mux;
  logic [NCNT-1:0]       sample_bits;
  logic                  start_take;
  logic                  accum_en;

  ritc_bit_sync #(.WIDTH(NDAT), .STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(user_clk_i), .rst_n(user_rst_n_i), .d(dat_in_i), .q(dat_q_o)
  );

  ritc_bit_sync #(.WIDTH(NUM_CH), .STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(user_clk_i), .rst_n(user_rst_n_i), .d(clk_in_i), .q(clk_q_o)
  );

  ritc_bit_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_vcdl (
    .clk(user_clk_i), .rst_n(user_rst_n_i), .d(vcdl_in_i), .q(vcdl_q_o)
  );

  assign sample_bits[NDAT-1:0]               = dat_q_o;
  assign sample_bits[CLK_BASE +: NUM_CH]     = clk_q_o;
  assign sample_bits[VCDL_IDX]               = vcdl_q_o;

  assign start_take = (state_q == ST_IDLE) && scan_start_i;

  // ACCUM runs one extra cycle to compare the registered sample count
  // against the latched length, so no sample is taken in that cycle.
  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_start_i) next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (scan_abort_i) next_state = ST_IDLE;
        else if (settle_cnt == SETTLE_W'(SYNC_STAGES - 1))
          next_state = (len_q == '0) ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (scan_abort_i) next_state = ST_IDLE;
        else if (sample_cnt == len_q) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign accum_en = (state_q == ST_ACCUM) && (next_state == ST_ACCUM);

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state_q         <= ST_IDLE;
      settle_cnt      <= '0;
      sample_cnt      <= '0;
      len_q           <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      results_valid_o <= 1'b0;
    end else begin
      state_q    <= next_state;
      busy_o     <= (next_state == ST_SETTLE) || (next_state == ST_ACCUM);
      done_o     <= (next_state == ST_DONE);
      settle_cnt <= (state_q == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      sample_cnt <= (state_q == ST_ACCUM) ? sample_cnt + 1'b1 : '0;
      if (start_take) begin
        len_q           <= scan_len_i;
        results_valid_o <= 1'b0;
      end else if (next_state == ST_DONE) begin
        results_valid_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else if (start_take) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
    end else if (accum_en) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= cnt[i] + CNT_WIDTH'(sample_bits[i]);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_addr_i == ADDR_WIDTH'(i)) rd_mux = cnt[i];
    end
  end

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) rd_data_o <= '0;
    else rd_data_o <= addr_in_range(int'(rd_addr_i), NCNT) ? rd_mux : '0;
  end

endmodule

// File: tb/tb_ritc_phase_scan_accumulator.sv
// Self-checking bench: per-cycle input history feeds a ones-count model of
// the samples taken in the scan window following each start.
module tb_ritc_phase_scan_accumulator;

  localparam int NUM_CH      = 3;
  localparam int NUM_BITS    = 12;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_WIDTH   = 16;
  localparam int ADDR_WIDTH  = 6;
  localparam int NDAT        = NUM_CH * NUM_BITS;
  localparam int NCNT        = NDAT + NUM_CH + 1;
  localparam int NADDR       = 1 << ADDR_WIDTH;
  localparam int HIST        = 2048;

  logic                       user_clk_i = 1'b0;
  logic                       user_rst_n_i = 1'b0;
  logic [NUM_CH-1:0]          clk_in_i = '0;
  logic [NDAT-1:0]            dat_in_i = '0;
  logic                       vcdl_in_i = 1'b0;
  logic [NUM_CH-1:0]          clk_q_o;
  logic [NDAT-1:0]            dat_q_o;
  logic                       vcdl_q_o;
  logic                       scan_start_i = 1'b0;
  logic                       scan_abort_i = 1'b0;
  logic [CNT_WIDTH-1:0]       scan_len_i = '0;
  logic                       busy_o, done_o, results_valid_o;
  logic [ADDR_WIDTH-1:0]      rd_addr_i = '0;
  logic [CNT_WIDTH-1:0]       rd_data_o;

  int checks = 0;
  int errors = 0;

  logic [NCNT-1:0]      hist      [HIST];
  logic                 busy_hist [HIST];
  logic                 rv_hist   [HIST];
  int                   exp_cnt   [NADDR];
  logic [CNT_WIDTH-1:0] rb        [NADDR];
  int                   done_cyc;
  int                   done_cnt;

  ritc_phase_scan_accumulator #(
    .NUM_CH(NUM_CH), .NUM_BITS(NUM_BITS), .SYNC_STAGES(SYNC_STAGES),
    .CNT_WIDTH(CNT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .user_clk_i(user_clk_i), .user_rst_n_i(user_rst_n_i),
    .clk_in_i(clk_in_i), .dat_in_i(dat_in_i), .vcdl_in_i(vcdl_in_i),
    .clk_q_o(clk_q_o), .dat_q_o(dat_q_o), .vcdl_q_o(vcdl_q_o),
    .scan_start_i(scan_start_i), .scan_abort_i(scan_abort_i), .scan_len_i(scan_len_i),
    .busy_o(busy_o), .done_o(done_o), .results_valid_o(results_valid_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
  );

  always #5 user_clk_i = ~user_clk_i;

  // mode 0: all ones, 1: index 17 toggles, 2: random, other: all zero
  function automatic logic [NCNT-1:0] gen_vec(input int mode, input int c);
    logic [NCNT-1:0] v;
    logic [63:0] r;
    v = '0;
    case (mode)
      0: v = '1;
      1: v[17] = c[0];
      2: begin
        r = {$urandom, $urandom};
        v = r[NCNT-1:0];
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic drive_vec(input logic [NCNT-1:0] v);
    dat_in_i  = v[NDAT-1:0];
    clk_in_i  = v[NDAT +: NUM_CH];
    vcdl_in_i = v[NCNT-1];
  endtask

  // Cycle 0 carries the start request; cycle c>=1 is c cycles later.
  task automatic run_scan(input int len, input int mode, input int abort_at,
                          input int restart_at, input int restart_len);
    int budget;
    budget = len + SYNC_STAGES + 6;
    @(posedge user_clk_i); #1;
    scan_start_i = 1'b1;
    scan_len_i   = CNT_WIDTH'(len);
    scan_abort_i = (abort_at == 0);
    hist[0] = gen_vec(mode, 0);
    drive_vec(hist[0]);
    done_cyc = -1;
    done_cnt = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge user_clk_i); #1;
      scan_start_i = (c == restart_at);
      if (c == restart_at) scan_len_i = CNT_WIDTH'(restart_len);
      scan_abort_i = (c == abort_at);
      hist[c] = gen_vec(mode, c);
      drive_vec(hist[c]);
      @(negedge user_clk_i);
      busy_hist[c] = busy_o;
      rv_hist[c]   = results_valid_o;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (mode == 2 && c >= SYNC_STAGES) begin
        checks++;
        if ({vcdl_q_o, clk_q_o, dat_q_o} !== hist[c-SYNC_STAGES]) begin
          errors++;
          $display("[TB] FAIL resync cycle %0d: got %h expected %h", c,
                   {vcdl_q_o, clk_q_o, dat_q_o}, hist[c-SYNC_STAGES]);
        end
      end
    end
    scan_start_i = 1'b0;
    scan_abort_i = 1'b0;
  endtask

  function automatic void compute_expected(input int len);
    for (int a = 0; a < NADDR; a++) exp_cnt[a] = 0;
    for (int k = 1; k <= len; k++)
      for (int i = 0; i < NCNT; i++) exp_cnt[i] += int'(hist[k][i]);
  endfunction

  task automatic read_all();
    @(posedge user_clk_i); #1;
    rd_addr_i = '0;
    for (int a = 0; a < NADDR; a++) begin
      @(posedge user_clk_i); #1;
      if (a < NADDR - 1) rd_addr_i = ADDR_WIDTH'(a + 1);
      @(negedge user_clk_i);
      rb[a] = rd_data_o;
    end
  endtask

  task automatic test_reset();
    drive_vec('1);
    repeat (3) @(posedge user_clk_i);
    @(negedge user_clk_i);
    checks++;
    if ({busy_o, done_o, results_valid_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {busy_o, done_o, results_valid_o});
    end
    checks++;
    if ({vcdl_q_o, clk_q_o, dat_q_o} !== '0 || rd_data_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got q=%h rd=%0d expected 0", {vcdl_q_o, clk_q_o, dat_q_o}, rd_data_o);
    end
    @(posedge user_clk_i); #1;
    user_rst_n_i = 1'b1;
    @(posedge user_clk_i); #1;
    scan_start_i = 1'b1;
    scan_len_i   = 16'd100;
    @(posedge user_clk_i); #1;
    scan_start_i = 1'b0;
    repeat (20) @(posedge user_clk_i);
    @(negedge user_clk_i);
    checks++;
    if (busy_o !== 1'b1 || dat_q_o !== '1) begin
      errors++;
      $display("[TB] FAIL pre_reset_busy: got busy=%b dat_q=%h expected busy=1 all ones", busy_o, dat_q_o);
    end
    #2;
    user_rst_n_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, results_valid_o} !== 3'b000 || dat_q_o !== '0 || rd_data_o !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got flags=%b dat_q=%h rd=%0d expected 0",
               {busy_o, done_o, results_valid_o}, dat_q_o, rd_data_o);
    end
    read_all();
    for (int a = 0; a < NADDR; a++) begin
      checks++;
      if (rb[a] !== '0) begin
        errors++;
        $display("[TB] FAIL reset_held_read addr %0d: got %0d expected 0", a, rb[a]);
      end
    end
    @(posedge user_clk_i); #1;
    user_rst_n_i = 1'b1;
    read_all();
    for (int a = 0; a < NADDR; a++) begin
      checks++;
      if (rb[a] !== '0) begin
        errors++;
        $display("[TB] FAIL reset_release_read addr %0d: got %0d expected 0", a, rb[a]);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_all_ones();
    run_scan(100, 0, -1, -1, 0);
    checks++;
    if (done_cnt != 1 || done_cyc != SYNC_STAGES + 102) begin
      errors++;
      $display("[TB] FAIL ones_done: got count=%0d cycle=%0d expected 1 at %0d",
               done_cnt, done_cyc, SYNC_STAGES + 102);
    end
    checks++;
    if (busy_hist[1] !== 1'b1 || busy_hist[SYNC_STAGES+102] !== 1'b0 || rv_hist[SYNC_STAGES+102] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ones_flags: got busy1=%b busyD=%b rvD=%b expected 1 0 1",
               busy_hist[1], busy_hist[SYNC_STAGES+102], rv_hist[SYNC_STAGES+102]);
    end
    compute_expected(100);
    read_all();
    for (int a = 0; a < NADDR; a++) begin
      checks++;
      if (rb[a] !== CNT_WIDTH'(exp_cnt[a])) begin
        errors++;
        $display("[TB] FAIL ones_count addr %0d: got %0d expected %0d", a, rb[a], exp_cnt[a]);
      end
    end
  endtask

  task automatic test_toggle();
    run_scan(1000, 1, -1, -1, 0);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL toggle_done: got %0d expected 1", done_cnt);
    end
    compute_expected(1000);
    read_all();
    for (int a = 0; a < NADDR; a++) begin
      checks++;
      if (rb[a] !== CNT_WIDTH'(exp_cnt[a])) begin
        errors++;
        $display("[TB] FAIL toggle_count addr %0d: got %0d expected %0d", a, rb[a], exp_cnt[a]);
      end
    end
    @(posedge user_clk_i); #1;
    rd_addr_i = 6'd16;
    @(posedge user_clk_i); #1;
    rd_addr_i = 6'd17;
    @(negedge user_clk_i);
    checks++;
    if (rd_data_o !== CNT_WIDTH'(exp_cnt[16])) begin
      errors++;
      $display("[TB] FAIL read_latency_old: got %0d expected %0d", rd_data_o, exp_cnt[16]);
    end
    @(negedge user_clk_i);
    checks++;
    if (rd_data_o !== CNT_WIDTH'(exp_cnt[17])) begin
      errors++;
      $display("[TB] FAIL read_latency_new: got %0d expected %0d", rd_data_o, exp_cnt[17]);
    end
  endtask

  task automatic test_abort();
    run_scan(1000, 2, 300, -1, 0);
    checks++;
    if (done_cnt != 0 || results_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_done: got count=%0d rv=%b expected 0 0", done_cnt, results_valid_o);
    end
    checks++;
    if (busy_hist[300] !== 1'b1 || busy_hist[301] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_busy: got %b%b expected 10", busy_hist[300], busy_hist[301]);
    end
    run_scan(60, 2, -1, -1, 0);
    checks++;
    if (done_cnt != 1 || done_cyc != SYNC_STAGES + 62) begin
      errors++;
      $display("[TB] FAIL after_abort_done: got count=%0d cycle=%0d expected 1 at %0d",
               done_cnt, done_cyc, SYNC_STAGES + 62);
    end
    compute_expected(60);
    read_all();
    for (int a = 0; a < NADDR; a++) begin
      checks++;
      if (rb[a] !== CNT_WIDTH'(exp_cnt[a])) begin
        errors++;
        $display("[TB] FAIL after_abort_count addr %0d: got %0d expected %0d", a, rb[a], exp_cnt[a]);
      end
    end
  endtask

  task automatic test_back_to_back_start();
    run_scan(50, 2, -1, SYNC_STAGES + 10, 7);
    checks++;
    if (done_cnt != 1 || done_cyc != SYNC_STAGES + 52) begin
      errors++;
      $display("[TB] FAIL busy_start_done: got count=%0d cycle=%0d expected 1 at %0d",
               done_cnt, done_cyc, SYNC_STAGES + 52);
    end
    compute_expected(50);
    read_all();
    for (int a = 0; a < NADDR; a++) begin
      checks++;
      if (rb[a] !== CNT_WIDTH'(exp_cnt[a])) begin
        errors++;
        $display("[TB] FAIL busy_start_count addr %0d: got %0d expected %0d", a, rb[a], exp_cnt[a]);
      end
    end
    run_scan(40, 2, 0, -1, 0);
    checks++;
    if (done_cnt != 1 || done_cyc != SYNC_STAGES + 42) begin
      errors++;
      $display("[TB] FAIL start_abort_same: got count=%0d cycle=%0d expected 1 at %0d",
               done_cnt, done_cyc, SYNC_STAGES + 42);
    end
  endtask

  task automatic test_zero_len();
    run_scan(0, 0, -1, -1, 0);
    checks++;
    if (done_cnt != 1 || done_cyc != SYNC_STAGES + 1 || rv_hist[SYNC_STAGES+1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_done: got count=%0d cycle=%0d rv=%b expected 1 at %0d rv=1",
               done_cnt, done_cyc, rv_hist[SYNC_STAGES+1], SYNC_STAGES + 1);
    end
    compute_expected(0);
    read_all();
    for (int a = 0; a < NADDR; a++) begin
      checks++;
      if (rb[a] !== CNT_WIDTH'(exp_cnt[a])) begin
        errors++;
        $display("[TB] FAIL zero_count addr %0d: got %0d expected %0d", a, rb[a], exp_cnt[a]);
      end
    end
    @(posedge user_clk_i); #1;
    scan_abort_i = 1'b1;
    @(posedge user_clk_i); #1;
    scan_abort_i = 1'b0;
    @(negedge user_clk_i);
    checks++;
    if (results_valid_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_abort: got rv=%b busy=%b expected 1 0", results_valid_o, busy_o);
    end
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 3; n++) begin
      len = $urandom_range(1, 150);
      run_scan(len, 2, -1, -1, 0);
      checks++;
      if (done_cnt != 1 || done_cyc != SYNC_STAGES + len + 2) begin
        errors++;
        $display("[TB] FAIL random_done len %0d: got count=%0d cycle=%0d expected 1 at %0d",
                 len, done_cnt, done_cyc, SYNC_STAGES + len + 2);
      end
      compute_expected(len);
      read_all();
      for (int a = 0; a < NADDR; a++) begin
        checks++;
        if (rb[a] !== CNT_WIDTH'(exp_cnt[a])) begin
          errors++;
          $display("[TB] FAIL random_count len %0d addr %0d: got %0d expected %0d",
                   len, a, rb[a], exp_cnt[a]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_toggle();
    test_abort();
    test_back_to_back_start();
    test_zero_len();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
